// File: rtl/csd_encoder_if.sv
// Request/result bundle for the binary-to-CSD encoder.
// The master drives start/dataIn. The slave returns the memory write stream and the status.
interface csd_encoder_if #(
  parameter int DATA_W = 15,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 5
);
  logic              start;
  logic [DATA_W-1:0] dataIn;
  logic              weCsd;
  logic [ADDR_W-1:0] address;
  logic [7:0]        dataOut;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  nzCount;

  modport master (output start, dataIn,
                  input  weCsd, address, dataOut, busy, done, nzCount);
  modport slave  (input  start, dataIn,
                  output weCsd, address, dataOut, busy, done, nzCount);
endinterface

// File: rtl/csd_encoder.sv
// Sequential binary-to-CSD encoder. It writes one signed digit per cycle (01/00/FF), LSB first.
// Defining CSD_SIGNED_EN treats dataIn as two's complement. Otherwise dataIn is unsigned.
module csd_encoder #(
  parameter int DATA_W = 15,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 5
) (
  input  logic         clk,
  input  logic         reset,
  csd_encoder_if.slave bus
);
  localparam int IW = $clog2(DATA_W + 2);

  typedef enum logic [1:0] {IDLE, ENCODE, DONE} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  nz_q, nz_d;

  logic              ext;
  logic [DATA_W+1:0] xe;
  logic              a, b, c_next, dig_nz;
  logic [7:0]        dig_byte;
  logic              last;

`ifdef CSD_SIGNED_EN
  assign ext = x_q[DATA_W-1];
`else
  assign ext = 1'b0;
`endif

  // Two extension bits cover x[i+1] at the final digit i = DATA_W.
  assign xe     = {ext, ext, x_q};
  assign a      = xe[IW'(idx_q)];
  assign b      = xe[IW'(idx_q) + IW'(1)];
  assign c_next = (a & b) | (a & carry_q) | (b & carry_q);
  // The digit is nonzero only when a+carry is odd. Its sign then follows the next bit.
  assign dig_nz   = a ^ carry_q;
  assign dig_byte = dig_nz ? (b ? 8'hFF : 8'h01) : 8'h00;
  assign last     = (idx_q == ADDR_W'(DATA_W));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    nz_d    = nz_q;
    case (state_q)
      IDLE: if (bus.start) begin
        x_d     = bus.dataIn;
        idx_d   = '0;
        carry_d = 1'b0;
        nz_d    = '0;
        state_d = ENCODE;
      end
      ENCODE: begin
        carry_d = c_next;
        idx_d   = idx_q + ADDR_W'(1);
        if (dig_nz) nz_d = nz_q + CNT_W'(1);
        if (last) begin
          carry_d = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      nz_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      nz_q    <= nz_d;
    end
  end

  assign bus.weCsd   = (state_q == ENCODE);
  assign bus.address = (state_q == ENCODE) ? idx_q : '0;
  assign bus.dataOut = (state_q == ENCODE) ? dig_byte : 8'h00;
  assign bus.busy    = (state_q == ENCODE);
  assign bus.done    = (state_q == DONE);
  assign bus.nzCount = nz_q;
endmodule

// File: tb/tb_csd_encoder.sv
// Self-checking bench for csd_encoder. It uses a vector table and random operands.
// A queue of expected {address, digit} writes is filled on each start and drained as the write stream appears.
module tb_csd_encoder;
  localparam int DATA_W = 15;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 5;
  localparam int ND     = DATA_W + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  csd_encoder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
  csd_encoder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [DATA_W-1:0] din;
    logic [ND-1:0]     pos;
    logic [ND-1:0]     neg;
    int                nz;
  } vec_t;

  vec_t        tbl[$];
  logic [11:0] exp_q[$];
  logic [7:0]  dig_b[ND];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int ext_val(input logic [DATA_W-1:0] d);
`ifdef CSD_SIGNED_EN
    return int'({{(32-DATA_W){d[DATA_W-1]}}, d});
`else
    return int'({{(32-DATA_W){1'b0}}, d});
`endif
  endfunction

  // Non-adjacent form via the 3x identity: d_i = bit(i+1) of 3v minus bit(i+1) of v.
  function automatic vec_t naf_model(input logic [DATA_W-1:0] d);
    vec_t r;
    int v, t;
    logic [31:0] tv, vv;
    v = ext_val(d);
    t = 3 * v;
    tv = t; vv = v;
    r.din = d; r.pos = '0; r.neg = '0; r.nz = 0;
    for (int k = 0; k < ND; k++) begin
      if (tv[k+1] && !vv[k+1]) begin r.pos[k] = 1'b1; r.nz++; end
      if (!tv[k+1] && vv[k+1]) begin r.neg[k] = 1'b1; r.nz++; end
    end
    return r;
  endfunction

  // mode 0: plain run. mode 1: a second start pulse at digit 5. mode 2: reset at digit 8.
  task automatic run_conv(input vec_t v, input int mode);
    int n;
    bit got;
    int sum, dv, prev_nz, adj;
    logic [11:0] e;
    for (int k = 0; k < ND; k++) dig_b[k] = 8'h5A;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.dataIn = v.din;
    for (int k = 0; k < ND; k++) begin
      logic [3:0] ka;
      ka = 4'(k);
      exp_q.push_back({ka, v.pos[k] ? 8'h01 : (v.neg[k] ? 8'hFF : 8'h00)});
    end
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    n = 0; got = 0;
    while (!got && n < 40) begin
      if (mode == 1) begin
        if (n == 5) begin bus.start = 1'b1; bus.dataIn = v.din ^ 15'h1234; end
        else bus.start = 1'b0;
      end
      if (mode == 2 && n == 8) begin
        reset = 1'b0;
        #1;
        chk("rst_weCsd", 32'(bus.weCsd), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_nzCount", 32'(bus.nzCount), 32'd0);
        chk("rst_address", 32'(bus.address), 32'd0);
        exp_q.delete();
        #2 reset = 1'b1;
        return;
      end
      if (bus.weCsd) begin
        if (exp_q.size() == 0) chk("unexpected_write", 32'(bus.address), 32'hFFFF);
        else begin
          e = exp_q.pop_front();
          chk("digit_write", 32'({bus.address, bus.dataOut}), 32'(e));
        end
        dig_b[bus.address] = bus.dataOut;
      end
      if (bus.done) begin
        got = 1;
        // done is the 17th cycle, counting the cycle right after the start edge as the first.
        chk("done_cycle", 32'(n), 32'(ND));
      end else begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    chk("nzCount", 32'(bus.nzCount), 32'(v.nz));
    chk("busy_in_done", 32'(bus.busy), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    sum = 0; prev_nz = 0; adj = 0;
    for (int k = 0; k < ND; k++) begin
      dv = (dig_b[k] == 8'h01) ? 1 : (dig_b[k] == 8'hFF) ? -1 : 0;
      if (dig_b[k] != 8'h01 && dig_b[k] != 8'hFF && dig_b[k] != 8'h00) adj++;
      if (dv != 0 && prev_nz != 0) adj++;
      prev_nz = dv;
      sum += dv * (1 << k);
    end
    chk("digit_sum", 32'(sum), 32'(ext_val(v.din)));
    chk("nonadjacent", 32'(adj), 32'd0);
    @(negedge clk);
    chk("done_pulse_end", 32'(bus.done), 32'd0);
    chk("idle_weCsd", 32'(bus.weCsd), 32'd0);
  endtask

  initial begin
    vec_t r;
    bus.start  = 1'b0;
    bus.dataIn = '0;
`ifdef CSD_SIGNED_EN
    tbl.push_back('{15'h7FFF, 16'h0000, 16'h0001, 1});
    tbl.push_back('{15'h4000, 16'h0000, 16'h4000, 1});
    tbl.push_back('{15'h0000, 16'h0000, 16'h0000, 0});
    tbl.push_back('{15'h0001, 16'h0001, 16'h0000, 1});
    tbl.push_back('{15'h0003, 16'h0004, 16'h0001, 2});
`else
    tbl.push_back('{15'h0003, 16'h0004, 16'h0001, 2});
    tbl.push_back('{15'h7FFF, 16'h8000, 16'h0001, 2});
    tbl.push_back('{15'h5555, 16'h5555, 16'h0000, 8});
    tbl.push_back('{15'h0000, 16'h0000, 16'h0000, 0});
    tbl.push_back('{15'h4000, 16'h4000, 16'h0000, 1});
    tbl.push_back('{15'h0001, 16'h0001, 16'h0000, 1});
`endif
    #12;
    chk("reset_weCsd", 32'(bus.weCsd), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_nzCount", 32'(bus.nzCount), 32'd0);
    chk("reset_dataOut", 32'(bus.dataOut), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) run_conv(tbl[i], 0);
    for (int i = 0; i < 6; i++) begin
      r = naf_model(15'($urandom_range(0, 32767)));
      run_conv(r, 0);
    end
    run_conv(tbl[0], 1);
    run_conv(tbl[0], 2);
    chk("post_reset_nzCount", 32'(bus.nzCount), 32'd0);
    run_conv(tbl[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
